// File: rtl/microsequencer_if.sv
// Sequencer bus: microstore write port, datapath condition/dispatch inputs
// and the control-word / state / fault outputs. clk and reset stay outside.
interface microsequencer_if #(
    parameter int STATE_W  = 7,
    parameter int CW_W     = 45,
    parameter int NUM_COND = 4
) ();
    localparam int CS_W = $clog2(NUM_COND);
    localparam int MW_W = CW_W + 3 + CS_W + 1 + STATE_W;

    logic                stall;
    logic [NUM_COND-1:0] cond_in;
    logic [STATE_W-1:0]  dispatch_addr;
    logic                us_we;
    logic [STATE_W-1:0]  us_waddr;
    logic [MW_W-1:0]     us_wdata;
    logic [CW_W-1:0]     ctrl_signals;
    logic [STATE_W-1:0]  active_state;
    logic                stack_err;

    modport master (
        output stall, cond_in, dispatch_addr, us_we, us_waddr, us_wdata,
        input  ctrl_signals, active_state, stack_err
    );

    modport slave (
        input  stall, cond_in, dispatch_addr, us_we, us_waddr, us_wdata,
        output ctrl_signals, active_state, stack_err
    );
endinterface

// File: rtl/microsequencer.sv
// Microprogrammed control sequencer: loadable microstore, microstate register
// and a small return stack. Each word's seq_op picks the next microstate.
//
//   seq_op       | meaning
//   -------------+---------------------------------------------------------
//   0 NEXT       | go to state+1 (wraps to 0 after the last word)
//   1 JUMP       | go to target
//   2 BRANCH     | go to target if condition, else state+1
//   3 DISPATCH   | go to dispatch_addr; out of range -> RESET_STATE + fault
//   4 CALL       | push state+1 and go to target; full stack -> fault, no push
//   5 RET        | pop and go there; empty stack -> RESET_STATE + fault
//   6 WAIT       | advance when condition true, otherwise hold
//   7 RESTART    | go to RESET_STATE and empty the stack
//
// Targets outside the microstore fall back to RESET_STATE without a fault.
module microsequencer #(
    parameter int STATE_W     = 7,
    parameter int DEPTH       = 128,
    parameter int CW_W        = 45,
    parameter int NUM_COND    = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_STATE = 0,
    parameter logic [CW_W-1:0] RESET_CW = '0
) (
    input  logic             clk,
    input  logic             reset,
    microsequencer_if.slave  bus
);
    localparam int CS_W  = $clog2(NUM_COND);
    localparam int MW_W  = CW_W + 3 + CS_W + 1 + STATE_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [2:0] {
        OP_NEXT     = 3'd0,
        OP_JUMP     = 3'd1,
        OP_BRANCH   = 3'd2,
        OP_DISPATCH = 3'd3,
        OP_CALL     = 3'd4,
        OP_RET      = 3'd5,
        OP_WAIT     = 3'd6,
        OP_RESTART  = 3'd7
    } seq_op_e;

    localparam logic [STATE_W:0] DEPTH_L = (STATE_W + 1)'(DEPTH);
    localparam state_t           LAST_ST = STATE_W'(DEPTH - 1);
    localparam state_t           RST_ST  = STATE_W'(RESET_STATE);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(STACK_DEPTH);

    logic [MW_W-1:0]    ustore [DEPTH];
    state_t             stack_q [STACK_DEPTH];
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_set, push;

    logic [MW_W-1:0]    word;
    logic [CW_W-1:0]    w_ctrl;
    seq_op_e            w_op;
    logic [CS_W-1:0]    w_sel;
    logic               w_inv;
    state_t             w_tgt;
    logic               cond;
    state_t             inc_st, tgt_st;
    logic               disp_ok;

    // Microstore write port; independent of reset and stall so code can be
    // reloaded at any time. Out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (bus.us_we && ({1'b0, bus.us_waddr} < DEPTH_L))
            ustore[bus.us_waddr[AW-1:0]] <= bus.us_wdata;
    end

    assign word    = ustore[state_q[AW-1:0]];
    assign w_ctrl  = word[MW_W-1 -: CW_W];
    assign w_op    = seq_op_e'(word[STATE_W+CS_W+3 -: 3]);
    assign w_sel   = word[STATE_W+CS_W -: CS_W];
    assign w_inv   = word[STATE_W];
    assign w_tgt   = word[STATE_W-1:0];

    assign cond    = bus.cond_in[w_sel] ^ w_inv;
    assign inc_st  = (state_q == LAST_ST) ? '0 : state_q + 1'b1;
    assign tgt_st  = ({1'b0, w_tgt} < DEPTH_L) ? w_tgt : RST_ST;
    assign disp_ok = ({1'b0, bus.dispatch_addr} < DEPTH_L);

    // Next-state, stack-pointer and fault decode from the current word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        err_set = 1'b0;
        case (w_op)
            OP_NEXT:   state_d = inc_st;
            OP_JUMP:   state_d = tgt_st;
            OP_BRANCH: state_d = cond ? tgt_st : inc_st;
            OP_DISPATCH: begin
                if (disp_ok) begin
                    state_d = bus.dispatch_addr;
                end else begin
                    state_d = RST_ST;
                    err_set = 1'b1;
                end
            end
            OP_CALL: begin
                state_d = tgt_st;
                if (cnt_q == FULL) begin
                    err_set = 1'b1;
                end else begin
                    push  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OP_RET: begin
                if (cnt_q == '0) begin
                    state_d = RST_ST;
                    err_set = 1'b1;
                end else begin
                    state_d = stack_q[SP_W'(cnt_q - 1'b1)];
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            OP_WAIT:    state_d = cond ? inc_st : state_q;
            OP_RESTART: begin
                state_d = RST_ST;
                cnt_d   = '0;
            end
            default:    state_d = inc_st;
        endcase
    end

    // State, stack pointer and sticky fault: reset wins, then stall holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_ST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (!bus.stall) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    // Return-stack storage; only slots below the pointer are ever read.
    always_ff @(posedge clk) begin
        if (!reset && !bus.stall && push)
            stack_q[SP_W'(cnt_q)] <= inc_st;
    end

    assign bus.ctrl_signals = reset ? RESET_CW : w_ctrl;
    assign bus.active_state = state_q;
    assign bus.stack_err    = err_q;

endmodule

// File: doc/microsequencer.md
# microsequencer

Parametrised microprogrammed control sequencer for the multicycle MIPS datapath. It holds a loadable microstore, a current-state register and a small return stack. Each cycle it drives the current microinstruction's control word to the datapath and selects the next state from the word's sequencing field: increment, jump, conditional branch, opcode dispatch, call/return, wait or restart. Condition flags and the dispatch address come from the datapath and opcode decoder.

## Interface
- STATE_W, 7, width of microstate address
- DEPTH, 128, microstore words; must satisfy 2 ≤ DEPTH ≤ 2**STATE_W
- CW_W, 45, datapath control-word width
- NUM_COND, 4, condition inputs; power of two, ≥ 2; CS_W = log2(NUM_COND)
- STACK_DEPTH, 4, return-stack entries, ≥ 1
- RESET_STATE, 0, state entered on reset or fault
- RESET_CW, 0, control word driven while reset is high
- Microword width MW_W = CW_W + 3 + CS_W + 1 + STATE_W
- Microword layout, MSB to LSB: ctrl[CW_W], seq_op[3], cond_sel[CS_W], cond_inv[1], target[STATE_W]

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  holds state and stack when high
- cond_in  in  NUM_COND  datapath condition flags (MOC, zero, ...)
- dispatch_addr  in  STATE_W  opcode-decoder target state
- us_we  in  1  microstore write enable
- us_waddr  in  STATE_W  microstore write address
- us_wdata  in  MW_W  microstore write data
- ctrl_signals  out  CW_W  control word to the datapath
- active_state  out  STATE_W  current microstate
- stack_err  out  1  sticky stack or dispatch fault flag

## Operation
- Microstore: DEPTH × MW_W array.
  - Written at the clock edge when us_we=1 and us_waddr < DEPTH. Out-of-range writes are ignored.
  - Writes take effect regardless of reset and stall. Contents are not cleared by reset.
- Read path: word = ustore[state_q], combinational. ctrl_signals = word.ctrl. While reset=1, ctrl_signals = RESET_CW.
- Condition: c = cond_in[cond_sel] ^ cond_inv.
- inc = (state_q == DEPTH-1) ? 0 : state_q+1. This wraps at the last word.
- Next state by seq_op:
  - 0 NEXT: inc
  - 1 JUMP: target
  - 2 BRANCH: c ? target : inc
  - 3 DISPATCH: dispatch_addr if < DEPTH; otherwise RESET_STATE and set stack_err
  - 4 CALL: push inc, then go to target. If the stack is full, do not push, set stack_err, still go to target.
  - 5 RET: pop and go to the popped value. If the stack is empty, go to RESET_STATE and set stack_err.
  - 6 WAIT: c ? inc : state_q (hold)
  - 7 RESTART: RESET_STATE, and the stack is cleared
- Any target ≥ DEPTH goes to RESET_STATE instead; stack_err is not set for this case.
- Return stack: LIFO of STACK_DEPTH entries, each STATE_W wide, with a count register.
- Priority: reset > stall > sequencing.
  - reset: state_q ← RESET_STATE, stack count ← 0, stack_err ← 0.
  - stall: state_q, stack and stack_err all hold.

## Timing
- One microinstruction per cycle. state_q updates on the rising edge. ctrl_signals and active_state are valid combinationally from state_q in the same cycle.
- Reset values after the edge with reset=1: active_state = RESET_STATE, stack empty, stack_err = 0. ctrl_signals = RESET_CW while reset is high, then ustore[RESET_STATE].
- Reset is sampled at the edge. Asserting it mid-CALL or mid-RET discards the pending push or pop.
- stack_err sets at the edge that executes the faulting op. It stays high until reset.
- Simultaneous microstore write to state_q: ctrl_signals shows the old word this cycle and the new word next cycle if state is held.
- cond_in and dispatch_addr are sampled only at the edge. They need no hold beyond setup/hold.
- CALL at stack full followed by RET returns to the most recent successfully pushed address.

## Test plan
- Reset and NEXT: load words 0..3 with NEXT and ctrl = 1,2,3,4. Hold reset 2 cycles, then release.
  - ctrl_signals = RESET_CW during reset.
  - Then ctrl_signals = 1,2,3,4 and active_state = 0,1,2,3.
- WAIT and BRANCH: word 5 = WAIT cond_sel=0; cond_in[0]=0 for 3 cycles, then 1.
  - active_state stays 5 for 3 cycles, then 6.
  - Word 6 = BRANCH target 20 with cond_inv=1 and cond_in[1]=0: next state is 20.
- DISPATCH: dispatch_addr=12 gives next state 12. With DEPTH=100 and dispatch_addr=110: next state 0 and stack_err=1.
- Call/return: with STACK_DEPTH=2, run nested CALLs from 10→30 and 30→40, then RET, RET.
  - States: 30, 40, 31, 11.
  - A third nested CALL sets stack_err and does not corrupt the returns.
  - RET on an empty stack goes to 0.
- Stall and wrap: assert stall for 4 cycles mid-sequence; state and stack hold.
  - NEXT at state DEPTH-1 gives state 0.
- Live reload: write word 3 while active_state=3 under stall. ctrl_signals changes one cycle after the write. Assert reset mid-sequence: state 0 next cycle and microstore contents retained.
